// File: rtl/link_pkg.sv
// ----------------------------------------------------------------------------
// link_pkg : types shared by the link transmitter, the link model and the
//            receive buffer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package link_pkg;

  localparam int LINK_WIDTH = 32;

  typedef logic [1:0] credit_t;

  typedef struct packed {
    logic [LINK_WIDTH-1:0] payload;
    logic                  valid;
    logic                  error;
  } link_beat_t;

  // Credits owed this cycle: one per freed slot plus one per corrupted beat.
  function automatic credit_t credit_sum(input logic a, input logic b);
    return credit_t'({1'b0, a}) + credit_t'({1'b0, b});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : registered-storage FIFO with first-word fall-through; pointers
//             wrap modulo DEPTH so DEPTH need not be a power of two.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/link_rx_buffer.sv
// ----------------------------------------------------------------------------
// link_rx_buffer : absorbs link beats into a FIFO, re-presents them on a
//                  valid/ready port and returns credits upstream.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module link_rx_buffer
  import link_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_p,
  input  logic                     in_valid,
  input  logic                     in_error,
  output logic [WIDTH-1:0]         out_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               credit_return,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             push_req;
  logic             overflow_evt;
  credit_t          credit_q;

  assign out_valid    = (fifo_count != '0);
  assign pop          = out_ready & ~fifo_empty;
  assign push_req     = in_valid & ~in_error;
  // A full FIFO with no pop has nowhere to put the beat: drop it, no credit.
  assign overflow_evt = push_req & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (in_p),
    .dout  (out_p),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q    <= '0;
      error_count <= '0;
      overflow    <= 1'b0;
    end else begin
      credit_q <= credit_sum(pop, in_error);
      if (in_error && (error_count != '1)) begin
        error_count <= error_count + ERR_ONE;
      end
      if (overflow_evt) begin
        overflow <= 1'b1;
      end
    end
  end

  assign credit_return = credit_q;

endmodule

`default_nettype wire

// File: doc/link_rx_buffer.md
Name: link_rx_buffer

Overview:
Receive-side stage that sits directly downstream of the point-to-point link (and of the link model in formal benches). The link output has no backpressure (valid only, plus a per-beat error flag), so this block absorbs every beat into a FIFO and re-presents it on a valid/ready interface. For each slot the downstream consumer frees and each beat the link corrupts, it returns one credit to the upstream transmitter. It also keeps error and overflow statistics.

Parameters:
WIDTH, 32, payload width in bits.
DEPTH, 4, FIFO entries. Must be >= 2. Equals the transmitter's initial credit count.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_p  input  WIDTH  payload from the link
in_valid  input  1  a beat arrives this cycle; cannot be stalled
in_error  input  1  the beat in this cycle was corrupted or lost on the link
out_p  output  WIDTH  head-of-FIFO payload
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head
credit_return  output  2  credits returned to the transmitter this cycle (0..2)
error_count  output  ERR_CNT_WIDTH  saturating count of error beats
overflow  output  1  sticky: a valid beat arrived while the FIFO was full and could not be stored

Behaviour:
- Single clock. All state is reset synchronously on rst=1.
- Reset values: out_valid=0, credit_return=0, error_count=0, overflow=0, FIFO empty, pointers=0. out_p is don't-care while out_valid=0.
- Push: a beat is pushed when in_valid=1 and in_error=0, subject to the full rule below.
- Error beat: when in_error=1, the beat is never stored, whatever the value of in_valid.
  - error_count increments by 1 and saturates at all-ones.
  - One credit is returned, because the transmitter spent a credit on it.
- Pop: occurs when out_valid=1 and out_ready=1. The head advances, and one credit is returned.
- Credit timing: credit_return is registered. It equals (number of pops in cycle N) + (number of error beats in cycle N), driven in cycle N+1. Range 0..2.
- Latency:
  - A beat pushed in cycle N is visible at out_p/out_valid in cycle N+1 (first-word fall-through from the registered FIFO).
  - An empty FIFO never bypasses combinationally.
- Occupancy counter: 0..DEPTH, width $clog2(DEPTH+1). Pointers wrap modulo DEPTH; DEPTH is not required to be a power of two.
- Full with simultaneous pop: push and pop in the same cycle while full → push is accepted and occupancy stays at DEPTH.
- Full without pop: a push in this case is an overflow.
  - The beat is dropped and overflow is set, staying set until rst.
  - No credit is returned, because the event is a protocol violation.
  - FIFO contents are unchanged.
- Empty with in_valid: push only; out_valid rises the next cycle.
- out_ready while empty: ignored. No pop, no credit.
- Payload stability: out_p and out_valid hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all stored beats are discarded and pending credits are not emitted. The transmitter is reset in the same domain and reloads DEPTH credits.
- Credit conservation invariant: credits held by the transmitter + credits in flight + occupancy + credit_return pending = DEPTH. This holds whenever overflow=0 and no beats are in flight on the link.

Decomposition:
- Package link_pkg holds:
  - the credit-count type (2 bits);
  - a typedef for the link beat {payload, valid, error}, so the transmitter, the link model and this block share it.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - ports: push, pop, din, dout, empty, full, count;
  - registered storage with first-word fall-through.
- link_rx_buffer adds the error/credit/overflow logic around sync_fifo.

Test Plan:
1. DEPTH=4, push 0xA1,0xA2,0xA3 on consecutive cycles with out_ready=0 → out_valid rises the cycle after the first push, out_p=0xA1 and held stable, credit_return=0 throughout.
2. Then out_ready=1 for 3 cycles → out_p sequence 0xA1,0xA2,0xA3. credit_return=1 in each of the three following cycles, then 0; out_valid=0 after the last pop.
3. in_valid=1, in_error=1 with payload 0xFF → nothing enqueued, error_count=1, credit_return=1 next cycle. Repeat 300 times with ERR_CNT_WIDTH=8 → error_count saturates at 255.
4. FIFO holds 1 beat. In the same cycle, pop and receive an error beat → credit_return=2 next cycle, occupancy 0.
5. Fill 4 beats, then push 0xB5 with out_ready=0 → overflow=1, 0xB5 never appears, no credit. Then push 0xB6 with out_ready=1 → 0xB6 accepted, occupancy stays 4.
6. Assert rst for one cycle with 3 beats queued and a pending credit → next cycle out_valid=0, credit_return=0, error_count=0, overflow=0. A subsequent push is delivered normally.
